// File: rtl/sga_input_pkg.sv
// Shared types and constants for the Snake Game Arcade input conditioner.
// Heading codes match the bit index of the corresponding key in the buttons vector.
package sga_input_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 0;

  // Positions of the non-direction keys in the combined key vector.
  localparam int KEY_START   = 4;
  localparam int KEY_PAUSE   = 5;
  localparam int KEY_RESTART = 6;
  localparam int NUM_KEYS    = 7;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b0001 << d;
  endfunction

  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/sga_input_conditioner_if.sv
// Raw key inputs and conditioned game inputs of the input conditioner.
// The slave side is the conditioner; the master side drives the raw keys.
interface sga_input_conditioner_if;

  logic [3:0] raw_buttons;
  logic       raw_start;
  logic       raw_pause;
  logic       raw_restart;

  logic [3:0] buttons;
  logic       start;
  logic       restart;
  logic       pause;
  logic [1:0] db_heading;

  modport master (
    output raw_buttons, raw_start, raw_pause, raw_restart,
    input  buttons, start, restart, pause, db_heading
  );

  modport slave (
    input  raw_buttons, raw_start, raw_pause, raw_restart,
    output buttons, start, restart, pause, db_heading
  );

endinterface

// File: rtl/sga_debouncer.sv
// Synchronizer plus counting debouncer for one raw key.
// press_o is a registered one-cycle pulse on each accepted 0->1 level change.
module sga_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  output logic press_o
);

  localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   sample;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign sample = sync_q[SYNC_STAGES-1];

  // The counter clears on terminal count, so it never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      stable_d = sample;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign press_d = stable_d & ~stable_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sga_input_conditioner.sv
// Input conditioner: seven debounced keys, reversal-rejecting direction filter,
// heading register, pause toggle and start/restart pulses. All outputs registered.
module sga_input_conditioner
  import sga_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input logic                    clock,
  input logic                    reset_n,
  sga_input_conditioner_if.slave io
);

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] press_keys;
  logic [3:0]          dir_press;
  logic                start_press;
  logic                pause_press;
  logic                restart_press;
  logic [3:0]          dir_ok;

  logic [3:0] buttons_q, buttons_d;
  logic       start_q, start_d;
  logic       restart_q, restart_d;
  logic       pause_q, pause_d;
  dir_t       heading_q, heading_d;

  assign raw_keys = {io.raw_restart, io.raw_pause, io.raw_start, io.raw_buttons};

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_db
    sga_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clock  (clock),
      .reset_n(reset_n),
      .raw_i  (raw_keys[gi]),
      .press_o(press_keys[gi])
    );
  end

  assign dir_press     = press_keys[3:0];
  assign start_press   = press_keys[KEY_START];
  assign pause_press   = press_keys[KEY_PAUSE];
  assign restart_press = press_keys[KEY_RESTART];

  // Filter uses the pre-toggle pause value; restart drops any same-cycle direction.
  always_comb begin
    dir_ok = dir_press & ~dir_onehot(dir_reverse(heading_q));
    if (pause_q || restart_press) begin
      dir_ok = '0;
    end
  end

  always_comb begin
    buttons_d = '0;
    heading_d = heading_q;
    if (dir_ok[BTN_LEFT]) begin
      buttons_d[BTN_LEFT] = 1'b1;
      heading_d           = DIR_LEFT;
    end else if (dir_ok[BTN_RIGHT]) begin
      buttons_d[BTN_RIGHT] = 1'b1;
      heading_d            = DIR_RIGHT;
    end else if (dir_ok[BTN_UP]) begin
      buttons_d[BTN_UP] = 1'b1;
      heading_d         = DIR_UP;
    end else if (dir_ok[BTN_DOWN]) begin
      buttons_d[BTN_DOWN] = 1'b1;
      heading_d           = DIR_DOWN;
    end
    if (restart_press) begin
      heading_d = DIR_RESET;
    end
  end

  assign pause_d   = restart_press ? 1'b0 : (pause_q ^ pause_press);
  assign start_d   = start_press;
  assign restart_d = restart_press;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buttons_q <= '0;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      pause_q   <= 1'b0;
      heading_q <= DIR_RESET;
    end else begin
      buttons_q <= buttons_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      pause_q   <= pause_d;
      heading_q <= heading_d;
    end
  end

  assign io.buttons    = buttons_q;
  assign io.start      = start_q;
  assign io.restart    = restart_q;
  assign io.pause      = pause_q;
  assign io.db_heading = heading_q;

endmodule

// File: tb/tb_sga_input_conditioner.sv
// Scoreboard bench for sga_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Stimulus queues expected output events; a negedge monitor pops and compares them.
module tb_sga_input_conditioner;

  localparam int DB  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + DB + 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  sga_input_conditioner_if bus ();

  sga_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .io     (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [3:0] b;
    logic       s;
    logic       r;
    logic       p;
    logic [1:0] h;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   errors = 0;
  int   checks = 0;
  logic pause_prev = 1'b0;

  // Any pulse or pause change is an output event that must match the queue head.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.buttons != 4'b0 || bus.start || bus.restart || bus.pause !== pause_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d buttons=%b start=%b restart=%b pause=%b heading=%0d, required no event",
                   cyc, bus.buttons, bus.start, bus.restart, bus.pause, bus.db_heading);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc != mon_e.t || bus.buttons !== mon_e.b || bus.start !== mon_e.s ||
              bus.restart !== mon_e.r || bus.pause !== mon_e.p || bus.db_heading !== mon_e.h) begin
            errors++;
            $display("FAIL event: got cyc=%0d buttons=%b start=%b restart=%b pause=%b heading=%0d, required cyc=%0d buttons=%b start=%b restart=%b pause=%b heading=%0d",
                     cyc, bus.buttons, bus.start, bus.restart, bus.pause, bus.db_heading,
                     mon_e.t, mon_e.b, mon_e.s, mon_e.r, mon_e.p, mon_e.h);
          end
        end
      end
    end
    pause_prev <= bus.pause;
  end

  task automatic drive_keys(input logic [6:0] k);
    bus.raw_buttons = k[3:0];
    bus.raw_start   = k[4];
    bus.raw_pause   = k[5];
    bus.raw_restart = k[6];
  endtask

  task automatic chk_idle(input string nm, input logic [1:0] h);
    checks++;
    if (bus.buttons !== 4'b0 || bus.start !== 1'b0 || bus.restart !== 1'b0 ||
        bus.pause !== 1'b0 || bus.db_heading !== h) begin
      errors++;
      $display("FAIL %s: buttons=%b start=%b restart=%b pause=%b heading=%0d, required zeros and heading=%0d",
               nm, bus.buttons, bus.start, bus.restart, bus.pause, bus.db_heading, h);
    end
  endtask

  // keys: [3:0] left/right/up/down, [4] start, [5] pause, [6] restart
  task automatic press(input logic [6:0] k, input bit ev, input logic [3:0] b,
                       input logic s, input logic r, input logic p, input logic [1:0] h);
    ev_t e;
    @(negedge clock);
    drive_keys(k);
    if (ev) begin
      e = '{cyc + LAT, b, s, r, p, h};
      exp_q.push_back(e);
    end
    repeat (12) @(negedge clock);
    drive_keys(7'b0);
    repeat (12) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    drive_keys(7'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_idle("in_reset", 2'd2);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      chk_idle("post_reset_idle", 2'd2);
    end

    // Reversal from RIGHT: left rejected, down accepted
    press(7'b0001000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
    press(7'b0000001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0);
    press(7'b0001000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd3);

    // Bounce on up, then held high
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      bus.raw_buttons[1] = (i % 2 == 0);
      repeat (2) @(negedge clock);
    end
    bus.raw_buttons[1] = 1'b1;
    e = '{cyc + LAT, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd1};
    exp_q.push_back(e);
    repeat (12) @(negedge clock);
    drive_keys(7'b0);
    repeat (12) @(negedge clock);

    press(7'b0000100, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd2);
    // Up and down together with heading RIGHT: up wins
    press(7'b0000011, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd1);

    // Pause gating
    press(7'b0100000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
    press(7'b0000010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
    press(7'b0010000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1);
    press(7'b0100000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1);
    press(7'b0100000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);

    // Restart clears pause and resets heading; same-cycle direction dropped
    press(7'b1000000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2);
    press(7'b1000010, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2);

    // Pause and up together: filter sees pause=0
    press(7'b0100010, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1);
    press(7'b0100000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1);

    // Reset mid-count: in-flight press lost, re-debounce after release
    @(negedge clock);
    bus.raw_buttons = 4'b0010;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_idle("mid_reset", 2'd2);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    e = '{cyc + LAT, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd1};
    exp_q.push_back(e);
    repeat (12) @(negedge clock);
    drive_keys(7'b0);
    repeat (20) @(negedge clock);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: outstanding=%0d, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
